ierdna_tally: RTL

Downstream monitor for the `ierdna` combinational decoder. It registers the decoder outputs `anao`, `anaid` and `luap`, detects rising edges on each, and keeps a saturating count per output. A 4-phase request/acknowledge port lets a host read any count without stalling the counting.

---
 rtl/ierdna_pkg.sv | 8 +
 rtl/ierdna_edge_cnt.sv | 49 ++++
 rtl/ierdna_tally.sv | 76 +++++++
 3 files changed

// File: rtl/ierdna_pkg.sv
// ierdna_pkg: select codes and read FSM state type shared by ierdna_tally
package ierdna_pkg;
    localparam logic [1:0] SEL_ANAO  = 2'd0;
    localparam logic [1:0] SEL_ANAID = 2'd1;
    localparam logic [1:0] SEL_LUAP  = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;
    typedef enum logic {RD_IDLE, RD_WAIT_DROP} rd_state_t;
endpackage

// File: rtl/ierdna_edge_cnt.sv
// ierdna_edge_cnt: rising-edge detector feeding a saturating counter with sticky sat flag
module ierdna_edge_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             clr,
    input  logic             rdclr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);
    logic             s_q, s_d, p_q, p_d, sat_q, sat_d, edge_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign edge_w = s_q & ~p_q;
    assign cnt    = cnt_q;
    assign sat    = sat_q;
    // clr beats read-clear beats increment; a read-clear keeps a coincident edge
    always_comb begin
        s_d   = in;
        p_d   = s_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (rdclr) begin
            cnt_d = {{(CNT_W-1){1'b0}}, edge_w};
            sat_d = 1'b0;
        end else if (edge_w) begin
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            sat_d = sat_q | (&cnt_q);
        end
    end
    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            p_q   <= 1'b0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            p_q   <= p_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end
endmodule

// File: rtl/ierdna_tally.sv
// ierdna_tally: per-output edge counters for ierdna with a 4-phase read port
// optional IERDNA_TALLY_RDCLR_EN: accepted reads clear the selected counter
module ierdna_tally
    import ierdna_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             anao,
    input  logic             anaid,
    input  logic             luap,
    input  logic             clr,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic [2:0]       sat
);
    logic [2:0]       ch_in, rdclr;
    logic [CNT_W-1:0] cnt [3];
    logic [CNT_W-1:0] sel_cnt, data_q, data_d;
    logic             ack_q, ack_d, accept;
    rd_state_t        state_q, state_d;
    assign ch_in   = {luap, anaid, anao};
    assign accept  = (state_q == RD_IDLE) && rd_req;
    assign sel_cnt = rd_sel == SEL_ANAO  ? cnt[0] :
                     rd_sel == SEL_ANAID ? cnt[1] :
                     rd_sel == SEL_LUAP  ? cnt[2] : '0;
    assign rd_ack  = ack_q;
    assign rd_data = data_q;
`ifdef IERDNA_TALLY_RDCLR_EN
    assign rdclr = {3{accept}} & {rd_sel == SEL_LUAP, rd_sel == SEL_ANAID, rd_sel == SEL_ANAO};
`else
    assign rdclr = 3'b000;
`endif
    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_ch
            ierdna_edge_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .in    (ch_in[i]),
                .clr   (clr),
                .rdclr (rdclr[i]),
                .cnt   (cnt[i]),
                .sat   (sat[i])
            );
        end
    endgenerate
    // accept a request in IDLE, ack for one cycle, then wait for rd_req to drop
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        data_d  = data_q;
        if (accept) begin
            state_d = RD_WAIT_DROP;
            ack_d   = 1'b1;
            data_d  = sel_cnt;
        end else if (state_q == RD_WAIT_DROP && !rd_req) begin
            state_d = RD_IDLE;
        end
    end
    // read port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end
endmodule
